// File: rtl/statistics_pkg.sv
// Shared opcode constants and instruction-class type for the retired-instruction statistics block.
package statistics_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_R    = 2'd1,
        CLS_I    = 2'd2,
        CLS_J    = 2'd3
    } cls_t;

endpackage

// File: rtl/statistics_op_classifier.sv
// Maps a MIPS opcode field to its instruction class.
// Latency: purely combinational. Backpressure: none.
// Opcodes outside the supported set classify as CLS_NONE.
module statistics_op_classifier
    import statistics_pkg::*;
(
    input  logic [5:0] op_i,
    output cls_t       cls_o
);

    always_comb begin
        cls_o = CLS_NONE;
        case (op_i)
            OP_RTYPE:                   cls_o = CLS_R;
            OP_J, OP_JAL:               cls_o = CLS_J;
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LW, OP_SW: cls_o = CLS_I;
            default:                    cls_o = CLS_NONE;
        endcase
    end

endmodule

// File: rtl/statistics.sv
// Counts retired R/I/J-type instructions and elapsed cycles; outputs registered, 1-edge latency.
// Backpressure: none, one op sampled every edge. Define STATISTICS_SATURATE_EN to saturate counters instead of wrapping.
module statistics
    import statistics_pkg::*;
#(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    output logic [CNT_W-1:0] i,
    output logic [CNT_W-1:0] r,
    output logic [CNT_W-1:0] j,
    output logic [CNT_W-1:0] cnt_clk
);

    cls_t             cls;
    logic [CNT_W-1:0] i_q, r_q, j_q, clk_q;
    logic [CNT_W-1:0] i_d, r_d, j_d, clk_d;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
`ifdef STATISTICS_SATURATE_EN
        return (en && (v != '1)) ? v + 1'b1 : v;
`else
        return en ? v + 1'b1 : v;
`endif
    endfunction

    statistics_op_classifier u_classifier (
        .op_i  (op),
        .cls_o (cls)
    );

    always_comb begin
        i_d   = bump(i_q, cls == CLS_I);
        r_d   = bump(r_q, cls == CLS_R);
        j_d   = bump(j_q, cls == CLS_J);
        clk_d = bump(clk_q, 1'b1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_q   <= '0;
            r_q   <= '0;
            j_q   <= '0;
            clk_q <= '0;
        end else begin
            i_q   <= i_d;
            r_q   <= r_d;
            j_q   <= j_d;
            clk_q <= clk_d;
        end
    end

    assign i       = i_q;
    assign r       = r_q;
    assign j       = j_q;
    assign cnt_clk = clk_q;

endmodule

// File: tb/tb_statistics.sv
// Randomized and directed check of statistics against an unbounded-count reference model.
module tb_statistics;

    localparam int CNT_W = 11;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [5:0]       op;
    logic [CNT_W-1:0] i, r, j, cnt_clk;

    int total = 0;
    int bad   = 0;

    // reference: raw event counts since the last reset
    int m_i, m_r, m_j, m_c, m_none;

    int i_ops [12] = '{6'o04, 6'o05, 6'o10, 6'o11, 6'o12, 6'o13,
                       6'o14, 6'o15, 6'o16, 6'o17, 6'o43, 6'o53};

    statistics #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .i       (i),
        .r       (r),
        .j       (j),
        .cnt_clk (cnt_clk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int shown(input int n);
`ifdef STATISTICS_SATURATE_EN
        return (n > MAXV) ? MAXV : n;
`else
        return n % (MAXV + 1);
`endif
    endfunction

    // 0 none, 1 R, 2 I, 3 J
    function automatic int class_of(input int o);
        if (o == 0) return 1;
        if (o == 2 || o == 3) return 3;
        foreach (i_ops[k]) if (i_ops[k] == o) return 2;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".i"},   int'(i),       shown(m_i));
        check({tag, ".r"},   int'(r),       shown(m_r));
        check({tag, ".j"},   int'(j),       shown(m_j));
        check({tag, ".clk"}, int'(cnt_clk), shown(m_c));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".i"},   int'(i),       0);
        check({tag, ".r"},   int'(r),       0);
        check({tag, ".j"},   int'(j),       0);
        check({tag, ".clk"}, int'(cnt_clk), 0);
    endtask

    // Called just after a negedge: glitch op, settle, count one edge, check at next negedge.
    task automatic cycle(input int o, input string tag);
        op = 6'($urandom);
        #1 op = 6'(o);
        @(posedge clk);
        m_c++;
        case (class_of(o))
            1: m_r++;
            2: m_i++;
            3: m_j++;
            default: m_none++;
        endcase
        @(negedge clk);
        check_all(tag);
    endtask

    // Called just after a negedge: drop reset between edges, hold it across one edge, release.
    task automatic do_reset(input string tag);
        #2 reset = 1'b0;
        #1 check_zero({tag, ".async"});
        m_i = 0; m_r = 0; m_j = 0; m_c = 0; m_none = 0;
        op = 6'b000000;
        @(posedge clk);
        @(negedge clk);
        check_zero({tag, ".held"});
        reset = 1'b1;
    endtask

    initial begin
        int dir_ops [8] = '{6'o00, 6'o43, 6'o53, 6'o10, 6'o14, 6'o02, 6'o03, 6'o77};
        reset = 1'b1;
        op    = 6'b000000;
        m_i = 0; m_r = 0; m_j = 0; m_c = 0; m_none = 0;

        #2 reset = 1'b0;
        #1 check_zero("por");
        @(posedge clk);
        @(negedge clk);
        check_zero("por_edge");
        reset = 1'b1;

        foreach (dir_ops[k]) begin
            cycle(dir_ops[k], "dir");
            if (k == 0) begin
                check("dir1.r",   int'(r),       1);
                check("dir1.clk", int'(cnt_clk), 1);
            end
        end
        check("dir8.i",   int'(i),       4);
        check("dir8.r",   int'(r),       1);
        check("dir8.j",   int'(j),       2);
        check("dir8.clk", int'(cnt_clk), 8);
        cycle(6'o77, "dir9");
        check("dir9.clk", int'(cnt_clk), 9);
        check("dir9.i",   int'(i),       4);

        do_reset("rst1");
        for (int o = 0; o < 64; o++) cycle(o, "sweep");
        check("sweep.r",   int'(r),       1);
        check("sweep.j",   int'(j),       2);
        check("sweep.i",   int'(i),       12);
        check("sweep.clk", int'(cnt_clk), 64);

        do_reset("rst2");
        for (int k = 0; k < 5; k++) cycle(int'($urandom_range(0, 63)), "pre");
        do_reset("mid");

        for (int k = 0; k < 2048; k++) cycle(0, "ovf");
`ifdef STATISTICS_SATURATE_EN
        check("ovf.r",   int'(r),       MAXV);
        check("ovf.clk", int'(cnt_clk), MAXV);
`else
        check("ovf.r",   int'(r),       0);
        check("ovf.clk", int'(cnt_clk), 0);
`endif

        do_reset("rst3");
        for (int k = 0; k < 1000; k++) begin
            // bias toward classified opcodes so all classes get exercised
            int o;
            if ($urandom_range(0, 1) == 0) o = int'($urandom_range(0, 63));
            else o = i_ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 7) == 0) o = int'($urandom_range(0, 3));
            cycle(o, "rnd");
            check("rnd.sum", int'(i) + int'(r) + int'(j), int'(cnt_clk) - m_none);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
